// File: rtl/synth_midi_pkg.sv
// Shared types for the MIDI source arbiter: buffered entry payload, FSM states and
// the end-of-message test applied to each popped entry.
package synth_midi_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] nr;
    logic [7:0] data;
  } midi_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    EMIT,
    GAP
  } arb_state_t;

  // True when this entry is the last byte of its MIDI message.
  function automatic logic is_eom(input midi_entry_t e);
    logic eom;
    eom = 1'b1;
    case (e.status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: eom = (e.nr == 8'd2);
      4'hC, 4'hD:                   eom = (e.nr == 8'd1);
      4'hF: begin
        if (e.status == 8'hF0)    eom = (e.data == 8'hF7);
        else if (e.status[3])     eom = 1'b1;
        else                      eom = (e.nr == 8'd0);
      end
      default:                      eom = 1'b1;
    endcase
    return eom;
  endfunction

endpackage

// File: rtl/midi_entry_fifo.sv
// Synchronous show-ahead FIFO of midi_entry_t; writes while full and reads while
// empty are ignored.
module midi_entry_fifo
  import synth_midi_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  midi_entry_t wr_data_i,
  input  logic        rd_en_i,
  output midi_entry_t rd_data_c_o,
  output logic        full_c_o,
  output logic        empty_c_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  midi_entry_t      mem_q [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok     = wr_en_i & ~full_c_o;
  assign rd_ok     = rd_en_i & ~empty_c_o;
  assign rd_data_c_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/midi_source_arbiter.sv
// Merges the UART and CPU-port MIDI byte streams into one strobe stream, granting one
// source at a time and holding the grant until that source's message ends.
module midi_source_arbiter
  import synth_midi_pkg::*;
#(
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned OUT_GAP  = 4,
  parameter int unsigned LOCK_TMO = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset_reg_N,
  input  logic       byteready_u,
  input  logic [7:0] cur_status_u,
  input  logic [7:0] midibyte_nr_u,
  input  logic [7:0] midi_in_data_u,
  input  logic       byteready_c,
  input  logic [7:0] cur_status_c,
  input  logic [7:0] midibyte_nr_c,
  input  logic [7:0] midi_in_data_c,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic       owner,
  output logic       ovf_u,
  output logic       ovf_c,
  output logic       lock_tmo
);

  localparam int unsigned CNT_W = $clog2(OUT_GAP + 2);
  localparam int unsigned TMO_W = $clog2(LOCK_TMO + 1);

  // Input sampling and rising-edge detection.
  logic        br_u_q, br_u_prev_q, br_c_q, br_c_prev_q;
  midi_entry_t ent_u_q, ent_c_q;
  logic        push_u, push_c;

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      br_u_q      <= 1'b0;
      br_u_prev_q <= 1'b0;
      br_c_q      <= 1'b0;
      br_c_prev_q <= 1'b0;
      ent_u_q     <= '0;
      ent_c_q     <= '0;
    end else begin
      br_u_q      <= byteready_u;
      br_u_prev_q <= br_u_q;
      br_c_q      <= byteready_c;
      br_c_prev_q <= br_c_q;
      ent_u_q     <= {cur_status_u, midibyte_nr_u, midi_in_data_u};
      ent_c_q     <= {cur_status_c, midibyte_nr_c, midi_in_data_c};
    end
  end

  assign push_u = br_u_q & ~br_u_prev_q;
  assign push_c = br_c_q & ~br_c_prev_q;

  midi_entry_t head_u, head_c, head;
  logic        full_u, full_c, empty_u, empty_c;
  logic        pop_u, pop_c;

  midi_entry_fifo #(.AW(FIFO_AW)) u_fifo_uart (
    .clk_i       (CLOCK_50),
    .rst_ni      (reset_reg_N),
    .wr_en_i     (push_u),
    .wr_data_i   (ent_u_q),
    .rd_en_i     (pop_u),
    .rd_data_c_o (head_u),
    .full_c_o    (full_u),
    .empty_c_o   (empty_u)
  );

  midi_entry_fifo #(.AW(FIFO_AW)) u_fifo_cpu (
    .clk_i       (CLOCK_50),
    .rst_ni      (reset_reg_N),
    .wr_en_i     (push_c),
    .wr_data_i   (ent_c_q),
    .rd_en_i     (pop_c),
    .rd_data_c_o (head_c),
    .full_c_o    (full_c),
    .empty_c_o   (empty_c)
  );

  arb_state_t       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_owner_q, last_owner_d;
  logic             eom_q, eom_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             byteready_q, byteready_d;
  midi_entry_t      out_q, out_d;
  logic             owner_q, owner_d;
  logic             lock_tmo_q, lock_tmo_d;
  logic             ovf_u_q, ovf_u_d, ovf_c_q, ovf_c_d;
  logic             own_empty;
  logic             pick;

  assign head      = grant_q ? head_c : head_u;
  assign own_empty = grant_q ? empty_c : empty_u;

  // Grant, strobe and gap sequencing plus the lock timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    eom_d        = eom_q;
    cnt_d        = cnt_q;
    tmo_d        = '0;
    byteready_d  = byteready_q;
    out_d        = out_q;
    owner_d      = owner_q;
    lock_tmo_d   = 1'b0;
    pop_u        = 1'b0;
    pop_c        = 1'b0;
    pick         = ~last_owner_q;

    unique case (state_q)
      IDLE: begin
        if (!empty_u || !empty_c) begin
          if (empty_u)      pick = 1'b1;
          else if (empty_c) pick = 1'b0;
          grant_d      = pick;
          last_owner_d = pick;
          state_d      = OWN;
        end
      end
      OWN: begin
        if (!own_empty) begin
          pop_u       = ~grant_q;
          pop_c       = grant_q;
          out_d       = head;
          owner_d     = grant_q;
          eom_d       = is_eom(head);
          byteready_d = 1'b1;
          cnt_d       = '0;
          state_d     = EMIT;
        end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
          lock_tmo_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
        end
      end
      EMIT: begin
        if (cnt_q == CNT_W'(1)) begin
          byteready_d = 1'b0;
          cnt_d       = '0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(OUT_GAP - 1)) begin
          cnt_d   = '0;
          state_d = eom_q ? IDLE : OWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_u_d = ovf_u_q | (push_u & full_u);
    ovf_c_d = ovf_c_q | (push_c & full_c);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_owner_q <= 1'b1;
      eom_q        <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      byteready_q  <= 1'b0;
      out_q        <= '0;
      owner_q      <= 1'b0;
      lock_tmo_q   <= 1'b0;
      ovf_u_q      <= 1'b0;
      ovf_c_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      eom_q        <= eom_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      byteready_q  <= byteready_d;
      out_q        <= out_d;
      owner_q      <= owner_d;
      lock_tmo_q   <= lock_tmo_d;
      ovf_u_q      <= ovf_u_d;
      ovf_c_q      <= ovf_c_d;
    end
  end

  assign byteready    = byteready_q;
  assign cur_status   = out_q.status;
  assign midibyte_nr  = out_q.nr;
  assign midi_in_data = out_q.data;
  assign owner        = owner_q;
  assign ovf_u        = ovf_u_q;
  assign ovf_c        = ovf_c_q;
  assign lock_tmo     = lock_tmo_q;

endmodule
